// File: rtl/poly_operand_bank_if.sv
// poly_operand_bank_if
//   Handshake bundle for poly_operand_bank.
//   Load stream : in_sel_i, in_valid_i, in_data_i -> in_ready_o
//   Result in   : res_en_i, res_din_i (one N-word column) -> res_ready_o
//   Result out  : out_valid_o, out_data_o -> out_ready_i
//   master = word source / result sink, slave = the operand bank.
interface poly_operand_bank_if #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5
);
  logic [1:0]              in_sel_i;
  logic                    in_valid_i;
  logic [WORD_WIDTH-1:0]   in_data_i;
  logic                    in_ready_o;
  logic                    res_en_i;
  logic [N*WORD_WIDTH-1:0] res_din_i;
  logic                    res_ready_o;
  logic                    out_valid_o;
  logic [WORD_WIDTH-1:0]   out_data_o;
  logic                    out_ready_i;

  modport master (
    output in_sel_i, in_valid_i, in_data_i, res_en_i, res_din_i, out_ready_i,
    input  in_ready_o, res_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_sel_i, in_valid_i, in_data_i, res_en_i, res_din_i, out_ready_i,
    output in_ready_o, res_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/poly_operand_bank.sv
// poly_operand_bank
//   Operand/result register bank for the AMNS Montgomery multiplier.
//   A, B, M (N*S words) and M_prime_0 (N words) are loaded word-serially;
//   each accepted word enters the top word and the register shifts toward
//   word 0. RES collects S columns of N words, then drains N*S words.
// Ports:
//   clock_i, reset_i (async, active low), clear_i (sync clear of control)
//   bus                : poly_operand_bank_if.slave (load / capture / drain)
//   A_coeff_rot_i[S]   : per-chunk rotate of A
//   B_shift_i, M_shift_i, MP0_rot_i : register commands
//   A_dout_o, B_dout_o, M_dout_o, MP0_dout_o : taps to the DSP array
//   loaded_o[3:0] = {MP0,M,B,A} full flags, all_loaded_o = &loaded_o
// Build option:
//   POLY_BANK_ERR_EN adds err_o[2:0] (sticky): [0] load to full register,
//   [1] command dropped by load collision, [2] res_en_i during drain.
module poly_operand_bank #(
  parameter int WORD_WIDTH = 17,
  parameter int N          = 5,
  parameter int S          = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  poly_operand_bank_if.slave      bus,
  input  logic [S-1:0]            A_coeff_rot_i,
  input  logic                    B_shift_i,
  input  logic                    M_shift_i,
  input  logic                    MP0_rot_i,
  output logic [S*WORD_WIDTH-1:0] A_dout_o,
  output logic [N*WORD_WIDTH-1:0] B_dout_o,
  output logic [WORD_WIDTH-1:0]   M_dout_o,
  output logic [WORD_WIDTH-1:0]   MP0_dout_o,
  output logic [3:0]              loaded_o,
  output logic                    all_loaded_o
`ifdef POLY_BANK_ERR_EN
  ,
  output logic [2:0]              err_o
`endif
);
  localparam int DEPTH = N * S;
  localparam int CNT_W = $clog2(N * S + 1);
  localparam int CAP_W = $clog2(S + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN} state_t;

  logic [WORD_WIDTH-1:0] r_a   [DEPTH];
  logic [WORD_WIDTH-1:0] r_b   [DEPTH];
  logic [WORD_WIDTH-1:0] r_m   [DEPTH];
  logic [WORD_WIDTH-1:0] r_p   [N];
  logic [WORD_WIDTH-1:0] r_res [DEPTH];
  logic [WORD_WIDTH-1:0] w_a_next   [DEPTH];
  logic [WORD_WIDTH-1:0] w_b_next   [DEPTH];
  logic [WORD_WIDTH-1:0] w_m_next   [DEPTH];
  logic [WORD_WIDTH-1:0] w_p_next   [N];
  logic [WORD_WIDTH-1:0] w_res_next [DEPTH];

  logic [3:0]       w_loaded;
  logic             w_in_ready;
  logic             w_accept;
  logic [3:0]       w_acc;
  state_t           r_state, w_state_next;
  logic [CAP_W-1:0] r_cap_cnt;
  logic [CNT_W-1:0] r_drain_cnt;
  logic             w_capture;
  logic             w_xfer;
  logic             w_last_cap;
  logic             w_last_xfer;

  // ---------------- load handshake ----------------
  assign w_in_ready = !w_loaded[bus.in_sel_i];
  // clear_i swallows a same-cycle accept so the counters restart cleanly
  assign w_accept   = bus.in_valid_i & w_in_ready & !clear_i;
  assign w_acc      = {4{w_accept}} & (4'b0001 << bus.in_sel_i);

  assign bus.in_ready_o = w_in_ready;
  assign loaded_o       = w_loaded;
  assign all_loaded_o   = &w_loaded;

  // Per-register word counters; MP0 is only N words deep.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      localparam int DEP = (gi == 3) ? N : DEPTH;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(DEP - 1);
      logic [CNT_W-1:0] r_cnt;
      logic             r_full;
      always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
          r_cnt  <= '0;
          r_full <= 1'b0;
        end else if (clear_i) begin
          r_cnt  <= '0;
          r_full <= 1'b0;
        end else if (w_acc[gi]) begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_full <= 1'b1;
        end
      end
      assign w_loaded[gi] = r_full;
    end
  endgenerate

  // ---------------- operand next values (load beats command) ----------------
  always_comb begin
    w_a_next = r_a;
    if (w_acc[0]) begin
      for (int k = 0; k < DEPTH - 1; k++) w_a_next[k] = r_a[k+1];
      w_a_next[DEPTH-1] = bus.in_data_i;
    end else begin
      for (int j = 0; j < S; j++) begin
        if (A_coeff_rot_i[j]) begin
          for (int i = 0; i < N - 1; i++) w_a_next[N*j+i] = r_a[N*j+i+1];
          w_a_next[N*j+N-1] = r_a[N*j];
        end
      end
    end
  end

  always_comb begin
    w_b_next = r_b;
    if (w_acc[1]) begin
      for (int k = 0; k < DEPTH - 1; k++) w_b_next[k] = r_b[k+1];
      w_b_next[DEPTH-1] = bus.in_data_i;
    end else if (B_shift_i) begin
      for (int k = 0; k < DEPTH - 1; k++) w_b_next[k] = r_b[k+1];
      w_b_next[DEPTH-1] = '0;
    end
  end

  always_comb begin
    w_m_next = r_m;
    if (w_acc[2]) begin
      for (int k = 0; k < DEPTH - 1; k++) w_m_next[k] = r_m[k+1];
      w_m_next[DEPTH-1] = bus.in_data_i;
    end else if (M_shift_i) begin
      for (int k = 0; k < DEPTH - 1; k++) w_m_next[k] = r_m[k+1];
      w_m_next[DEPTH-1] = '0;
    end
  end

  always_comb begin
    w_p_next = r_p;
    if (w_acc[3]) begin
      for (int k = 0; k < N - 1; k++) w_p_next[k] = r_p[k+1];
      w_p_next[N-1] = bus.in_data_i;
    end else if (MP0_rot_i) begin
      for (int k = 0; k < N - 1; k++) w_p_next[k] = r_p[k+1];
      w_p_next[N-1] = r_p[0];
    end
  end

  // ---------------- result FSM ----------------
  assign w_capture   = bus.res_en_i & (r_state != ST_DRAIN) & !clear_i;
  assign w_xfer      = (r_state == ST_DRAIN) & bus.out_ready_i & !clear_i;
  assign w_last_cap  = (r_cap_cnt == CAP_W'(S - 1));
  assign w_last_xfer = (r_drain_cnt == CNT_W'(DEPTH - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (clear_i) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (w_capture) w_state_next = w_last_cap ? ST_DRAIN : ST_COLLECT;
        end
        ST_DRAIN: begin
          if (w_xfer && w_last_xfer) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.res_ready_o = (r_state != ST_DRAIN);
    bus.out_valid_o = (r_state == ST_DRAIN);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cap_cnt   <= '0;
      r_drain_cnt <= '0;
    end else if (clear_i) begin
      r_cap_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_capture) r_cap_cnt <= w_last_cap ? '0 : r_cap_cnt + 1'b1;
      if (w_xfer)    r_drain_cnt <= w_last_xfer ? '0 : r_drain_cnt + 1'b1;
    end
  end

  // Capture pushes a whole column into the top N words; drain pops word 0.
  always_comb begin
    w_res_next = r_res;
    if (w_capture) begin
      for (int k = 0; k < DEPTH - N; k++) w_res_next[k] = r_res[k+N];
      for (int i = 0; i < N; i++)
        w_res_next[DEPTH-N+i] = bus.res_din_i[i*WORD_WIDTH +: WORD_WIDTH];
    end else if (w_xfer) begin
      for (int k = 0; k < DEPTH - 1; k++) w_res_next[k] = r_res[k+1];
      w_res_next[DEPTH-1] = '0;
    end
  end

  assign bus.out_data_o = r_res[0];

  // ---------------- data storage ----------------
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_m[k]   <= '0;
        r_res[k] <= '0;
      end
      for (int k = 0; k < N; k++) r_p[k] <= '0;
    end else begin
      r_a   <= w_a_next;
      r_b   <= w_b_next;
      r_m   <= w_m_next;
      r_p   <= w_p_next;
      r_res <= w_res_next;
    end
  end

  // ---------------- output taps ----------------
  generate
    for (gi = 0; gi < S; gi++) begin : g_a_tap
      assign A_dout_o[gi*WORD_WIDTH +: WORD_WIDTH] = r_a[N*gi];
    end
    for (gi = 0; gi < N; gi++) begin : g_b_tap
      assign B_dout_o[gi*WORD_WIDTH +: WORD_WIDTH] = r_b[gi*S];
    end
  endgenerate

  assign M_dout_o   = r_m[0];
  assign MP0_dout_o = r_p[0];

`ifdef POLY_BANK_ERR_EN
  logic [2:0] r_err;
  logic [2:0] w_err_set;

  assign w_err_set[0] = bus.in_valid_i & !w_in_ready;
  assign w_err_set[1] = (w_acc[0] & |A_coeff_rot_i) | (w_acc[1] & B_shift_i) |
                        (w_acc[2] & M_shift_i)      | (w_acc[3] & MP0_rot_i);
  assign w_err_set[2] = bus.res_en_i & (r_state == ST_DRAIN);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)     r_err <= '0;
    else if (clear_i) r_err <= '0;
    else              r_err <= r_err | w_err_set;
  end

  assign err_o = r_err;
`endif
endmodule

// File: tb/tb_poly_operand_bank.sv
module tb_poly_operand_bank;
  localparam int WW = 17;
  localparam int N = 5;
  localparam int S = 4;
  localparam int DEPTH = N * S;

  typedef logic [WW-1:0] word_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic [S-1:0] a_rot = '0;
  logic b_shift = 1'b0, m_shift = 1'b0, p_rot = 1'b0;
  wire [S*WW-1:0] a_dout;
  wire [N*WW-1:0] b_dout;
  wire [WW-1:0]   m_dout, p_dout;
  wire [3:0]      loaded;
  wire            all_loaded;
`ifdef POLY_BANK_ERR_EN
  wire [2:0]      err;
`endif

  poly_operand_bank_if #(.WORD_WIDTH(WW), .N(N)) bus ();

  poly_operand_bank #(.WORD_WIDTH(WW), .N(N), .S(S)) dut (
    .clock_i(clk), .reset_i(rst_n), .clear_i(clear), .bus(bus),
    .A_coeff_rot_i(a_rot), .B_shift_i(b_shift), .M_shift_i(m_shift), .MP0_rot_i(p_rot),
    .A_dout_o(a_dout), .B_dout_o(b_dout), .M_dout_o(m_dout), .MP0_dout_o(p_dout),
    .loaded_o(loaded), .all_loaded_o(all_loaded)
`ifdef POLY_BANK_ERR_EN
    , .err_o(err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails = 0;

  // Reference model: registers as word queues, index 0 = word 0.
  word_t qa[$], qb[$], qm[$], qp[$], qr[$];
  int    mcnt[4];
  bit    mloaded[4];
  int    mcap, mxfer;
  bit    mdrain;
  logic [2:0] merr;

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int depth_of(int r);
    return (r == 3) ? N : DEPTH;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete(); qm.delete(); qp.delete(); qr.delete();
    repeat (DEPTH) begin
      qa.push_back('0); qb.push_back('0); qm.push_back('0); qr.push_back('0);
    end
    repeat (N) qp.push_back('0);
    for (int r = 0; r < 4; r++) begin mcnt[r] = 0; mloaded[r] = 0; end
    mcap = 0; mxfer = 0; mdrain = 0; merr = '0;
  endtask

  // Apply the spec's rules for one clock edge given the currently driven inputs.
  task automatic model_edge();
    int  sel;
    bit  acc;
    word_t t;
    sel = int'(bus.in_sel_i);
    acc = bus.in_valid_i && !mloaded[sel] && !clear;
    if (bus.in_valid_i && mloaded[sel]) merr[0] = 1'b1;
    if (acc && ((sel == 0 && a_rot != 0) || (sel == 1 && b_shift) ||
                (sel == 2 && m_shift) || (sel == 3 && p_rot))) merr[1] = 1'b1;
    if (bus.res_en_i && mdrain) merr[2] = 1'b1;
    // A
    if (acc && sel == 0) begin
      void'(qa.pop_front()); qa.push_back(bus.in_data_i);
    end else begin
      for (int j = 0; j < S; j++) if (a_rot[j]) begin
        t = qa[N*j];
        for (int i = 0; i < N - 1; i++) qa[N*j+i] = qa[N*j+i+1];
        qa[N*j+N-1] = t;
      end
    end
    // B, M, MP0
    if (acc && sel == 1) begin void'(qb.pop_front()); qb.push_back(bus.in_data_i); end
    else if (b_shift)    begin void'(qb.pop_front()); qb.push_back('0); end
    if (acc && sel == 2) begin void'(qm.pop_front()); qm.push_back(bus.in_data_i); end
    else if (m_shift)    begin void'(qm.pop_front()); qm.push_back('0); end
    if (acc && sel == 3) begin void'(qp.pop_front()); qp.push_back(bus.in_data_i); end
    else if (p_rot)      begin t = qp.pop_front(); qp.push_back(t); end
    // control
    if (clear) begin
      for (int r = 0; r < 4; r++) begin mcnt[r] = 0; mloaded[r] = 0; end
      mcap = 0; mdrain = 0; mxfer = 0; merr = '0;
    end else begin
      if (acc) begin
        mcnt[sel]++;
        if (mcnt[sel] == depth_of(sel)) mloaded[sel] = 1;
      end
      if (mdrain) begin
        if (bus.out_ready_i) begin
          void'(qr.pop_front()); qr.push_back('0);
          mxfer++;
          if (mxfer == DEPTH) mdrain = 0;
        end
      end else if (bus.res_en_i) begin
        repeat (N) void'(qr.pop_front());
        for (int i = 0; i < N; i++) qr.push_back(bus.res_din_i[i*WW +: WW]);
        mcap++;
        if (mcap == S) begin mdrain = 1; mcap = 0; mxfer = 0; end
      end
    end
  endtask

  task automatic check_all(string ph);
    logic [S*WW-1:0] ea;
    logic [N*WW-1:0] eb;
    for (int j = 0; j < S; j++) ea[j*WW +: WW] = qa[N*j];
    for (int i = 0; i < N; i++) eb[i*WW +: WW] = qb[i*S];
    check({ph, ".a_dout"}, 128'(a_dout), 128'(ea));
    check({ph, ".b_dout"}, 128'(b_dout), 128'(eb));
    check({ph, ".m_dout"}, 128'(m_dout), 128'(qm[0]));
    check({ph, ".mp0_dout"}, 128'(p_dout), 128'(qp[0]));
    check({ph, ".loaded"}, 128'(loaded), 128'({mloaded[3], mloaded[2], mloaded[1], mloaded[0]}));
    check({ph, ".all_loaded"}, 128'(all_loaded), 128'(mloaded[0] & mloaded[1] & mloaded[2] & mloaded[3]));
    check({ph, ".in_ready"}, 128'(bus.in_ready_o), 128'(!mloaded[int'(bus.in_sel_i)]));
    check({ph, ".res_ready"}, 128'(bus.res_ready_o), 128'(!mdrain));
    check({ph, ".out_valid"}, 128'(bus.out_valid_o), 128'(mdrain));
    check({ph, ".out_data"}, 128'(bus.out_data_o), 128'(qr[0]));
`ifdef POLY_BANK_ERR_EN
    check({ph, ".err"}, 128'(err), 128'(merr));
`endif
  endtask

  task automatic tick(string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  // Word-serial load with optional random valid gaps; bounded.
  task automatic load_seq(int sel, word_t words[$], bit gaps);
    int idx = 0;
    int guard = 0;
    while (idx < words.size() && guard < 400) begin
      bus.in_sel_i   = 2'(sel);
      bus.in_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_data_i  = words[idx];
      if (bus.in_valid_i && !mloaded[sel]) idx++;
      tick("load");
      guard++;
    end
    bus.in_valid_i = 1'b0;
    check("load_complete", 128'(idx), 128'(words.size()));
  endtask

  initial begin
    word_t ws[$];
    logic [S*WW-1:0] ea;
    logic [N*WW-1:0] eb;
    word_t got[$];
    int guard, ncap;
    word_t mp0_seq[5];

    bus.in_sel_i = '0; bus.in_valid_i = 0; bus.in_data_i = '0;
    bus.res_en_i = 0; bus.res_din_i = '0; bus.out_ready_i = 0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_reset");

    // A with 1..20, random gaps
    ws.delete();
    for (int k = 1; k <= DEPTH; k++) ws.push_back(word_t'(k));
    load_seq(0, ws, 1'b1);
    check("a_loaded", 128'(loaded), 128'(4'b0001));
    for (int j = 0; j < S; j++) ea[j*WW +: WW] = word_t'(1 + N*j);
    check("a_dout_1_6_11_16", 128'(a_dout), 128'(ea));
    bus.in_sel_i = 2'd0; bus.in_valid_i = 1'b1; bus.in_data_i = 17'h1abcd;
    #1;
    check("a_full_in_ready", 128'(bus.in_ready_o), 128'(1'b0));
    tick("a_stall");
    bus.in_valid_i = 1'b0;

    // B with 1..20, two shifts
    load_seq(1, ws, 1'b1);
    b_shift = 1'b1;
    tick("b_shift");
    tick("b_shift");
    b_shift = 1'b0;
    for (int i = 0; i < N; i++) eb[i*WW +: WW] = word_t'(3 + 4*i);
    check("b_dout_after_2_shifts", 128'(b_dout), 128'(eb));

    // M random, MP0 1..5 then rotate five times
    ws.delete();
    for (int k = 0; k < DEPTH; k++) ws.push_back(word_t'($urandom));
    load_seq(2, ws, 1'b1);
    ws.delete();
    for (int k = 1; k <= N; k++) ws.push_back(word_t'(k));
    load_seq(3, ws, 1'b0);
    check("all_loaded_after_loads", 128'(all_loaded), 128'(1'b1));
    mp0_seq = '{17'd2, 17'd3, 17'd4, 17'd5, 17'd1};
    p_rot = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick("mp0_rot");
      check("mp0_rot_seq", 128'(p_dout), 128'(mp0_seq[k]));
      check("mp0_loaded_stays", 128'(loaded[3]), 128'(1'b1));
    end
    p_rot = 1'b0;

    // Random commands and stalled loads on a fully loaded bank
    for (int k = 0; k < 40; k++) begin
      a_rot = S'($urandom); b_shift = 1'($urandom); m_shift = 1'($urandom); p_rot = 1'($urandom);
      bus.in_sel_i = 2'($urandom); bus.in_valid_i = 1'($urandom); bus.in_data_i = word_t'($urandom);
      tick("rand_cmd");
    end
    a_rot = '0; b_shift = 0; m_shift = 0; p_rot = 0; bus.in_valid_i = 0;

    // clear: control only, data kept
    clear = 1'b1;
    tick("clear");
    clear = 1'b0;
    check("clear_loaded", 128'(loaded), 128'(4'b0000));

    // A reload with a rotate colliding on an accept; B shift on another accept
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_sel_i = 2'd0; bus.in_valid_i = 1'b1; bus.in_data_i = word_t'(k + 1);
      a_rot   = (k == 2) ? 4'b0010 : 4'b0000;
      b_shift = (k == 5);
      tick("collide");
    end
    a_rot = '0; b_shift = 0; bus.in_valid_i = 0;
    for (int j = 0; j < S; j++) ea[j*WW +: WW] = word_t'(1 + N*j);
    check("collide_a_order", 128'(a_dout), 128'(ea));
`ifdef POLY_BANK_ERR_EN
    check("err_collision", 128'(err[1]), 128'(1'b1));
`endif

    // Capture 4 columns (col*10+i) with random gaps
    ncap = 0; guard = 0;
    while (ncap < S && guard < 200) begin
      bus.res_en_i = 1'($urandom);
      for (int i = 0; i < N; i++) bus.res_din_i[i*WW +: WW] = word_t'(ncap*10 + i);
      if (bus.res_en_i) ncap++;
      tick("capture");
      guard++;
    end
    bus.res_en_i = 1'b0;
    check("capture_done", 128'(ncap), 128'(S));
    check("out_valid_after_cap", 128'(bus.out_valid_o), 128'(1'b1));

    // Drain with out_ready toggling; stray captures must be ignored
    got.delete(); guard = 0;
    while (got.size() < DEPTH && guard < 200) begin
      bus.out_ready_i = guard[0];
      bus.res_en_i = 1'($urandom);
      bus.res_din_i = {N{17'h1ffff}};
      check("drain_res_ready", 128'(bus.res_ready_o), 128'(1'b0));
      if (bus.out_valid_o && bus.out_ready_i) got.push_back(bus.out_data_o);
      tick("drain");
      guard++;
    end
    bus.out_ready_i = 0; bus.res_en_i = 0;
    check("drain_count", 128'(got.size()), 128'(DEPTH));
    for (int k = 0; k < got.size(); k++)
      check("drain_word", 128'(got[k]), 128'((k / N) * 10 + (k % N)));
    check("out_valid_after_drain", 128'(bus.out_valid_o), 128'(1'b0));

    // Reset during a drain after 7 transfers
    for (int c = 0; c < S; c++) begin
      bus.res_en_i = 1'b1;
      for (int i = 0; i < N; i++) bus.res_din_i[i*WW +: WW] = word_t'($urandom);
      tick("cap2");
    end
    bus.res_en_i = 1'b0;
    bus.out_ready_i = 1'b1;
    repeat (7) tick("drain2");
    bus.out_ready_i = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_out_valid", 128'(bus.out_valid_o), 128'(1'b0));
    check("rst_res_word0", 128'(bus.out_data_o), 128'(0));
    check("rst_loaded", 128'(loaded), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready_o), 128'(1'b1));
    check_all("mid_drain_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/poly_operand_bank.md
Name: poly_operand_bank

Overview:
Parametrised operand/result register bank for the AMNS Montgomery multiplier datapath.
- Operand side: word-serial valid/ready load of A, B, M and M_prime_0, with per-register word counters and loaded flags.
- Result side: RES_reg captures S column results of N words each, then a drain FSM streams all N*S result words out over valid/ready.
- Sits between the BRAM/host word stream and the DSP coefficient array.

Parameters:
WORD_WIDTH, 17, width of one word (DSP operand width)
N, 5, coefficients per AMNS polynomial
S, 4, words per coefficient
CNT_W, $clog2(N*S+1), width of internal word counters (derived, not overridden)

Ports:
clock_i  in  1  clock, rising edge
reset_i  in  1  asynchronous active-low reset
clear_i  in  1  sync clear of load counters, loaded flags, result FSM (data retained)
in_sel_i  in  2  load target: 0 A, 1 B, 2 M, 3 M_prime_0
in_valid_i  in  1  load word valid
in_data_i  in  WORD_WIDTH  load word
in_ready_o  out  1  load word accepted when in_valid_i & in_ready_o
loaded_o  out  4  per-register full flag [A,B,M,MP0] = bits [0..3]
all_loaded_o  out  1  &loaded_o
A_coeff_rot_i  in  S  bit j rotates chunk j of A by one word
B_shift_i  in  1  shift B one word
M_shift_i  in  1  shift M one word
MP0_rot_i  in  1  rotate M_prime_0 one word
A_dout_o  out  S*WORD_WIDTH  word j = A word N*j
B_dout_o  out  N*WORD_WIDTH  word i = B word i*S
M_dout_o  out  WORD_WIDTH  M word 0
MP0_dout_o  out  WORD_WIDTH  M_prime_0 word 0
res_en_i  in  1  capture one N-word result column
res_din_i  in  N*WORD_WIDTH  result column
res_ready_o  out  1  capture allowed
out_valid_o  out  1  result word valid
out_data_o  out  WORD_WIDTH  RES word 0
out_ready_i  in  1  result sink ready

Behaviour:
- Reset (reset_i=0, async): all data regs 0, counters 0, loaded_o=0, all_loaded_o=0, in_ready_o=1, res_ready_o=1, out_valid_o=0, FSM IDLE.
- Depths: A, B, M = N*S words; M_prime_0 = N words.
- Load shift: accepted word enters top word, register shifts right one word. After a full load, the k-th accepted word (k from 0) sits at word index k.
- in_ready_o is combinational: !loaded_o[in_sel_i].
- Counter per register increments on accept. On reaching depth, loaded bit sets next cycle, and further words to that target stall.
- Commands:
  - A rotation: chunk j = words N*j..N*j+N-1; rotate right by one word within the chunk.
  - B/M shift: shift right one word, zero fill at top.
  - MP0 rotation: rotate right by one word.
- Simultaneous load accept and command on the same register: load wins, command dropped. Different registers: both act.
- Commands are legal whether or not the register is loaded. They never change counters or flags.
- RES FSM:
  - IDLE/COLLECT: res_ready_o=1. res_en_i shifts RES right by N words, res_din_i enters the top N words, capture count increments.
  - On the S-th capture, next state is DRAIN. out_valid_o=1 on the cycle after the S-th capture edge.
  - DRAIN: res_ready_o=0 and res_en_i is ignored. Each out_valid_o & out_ready_i shifts RES right one word.
  - After N*S transfers: IDLE, out_valid_o=0 the next cycle. out_data_o stays stable while stalled.
- clear_i: counters, loaded_o and capture count go to 0; FSM goes to IDLE and out_valid_o=0. Data regs are untouched. clear_i has priority over same-cycle accepts and captures.
- Reset asserted mid-load or mid-drain: immediate return to reset state.

Optional Feature:
POLY_BANK_ERR_EN:
- Defined: adds err_o [2:0], sticky, cleared by reset_i or clear_i.
  - Bit 0: load attempted to a full register (in_valid_i & !in_ready_o).
  - Bit 1: command dropped due to load collision.
  - Bit 2: res_en_i during DRAIN.
- Undefined: port absent, events silently handled as above.

Test Plan:
- Reset then load A with words 1..20 (N=5,S=4) -> loaded_o=0001 one cycle after the 20th accept; A_dout_o words = {1,6,11,16}; in_ready_o=0 for sel 0.
- Load B with 1..20, assert B_shift_i twice -> B_dout_o words {3,7,11,15,19}.
- Load MP0 with 1..5, MP0_rot_i x5 -> MP0_dout_o sequence 2,3,4,5,1; loaded_o[3] stays 1.
- Capture 4 columns c0..c3, each word = column*10+i -> out_valid_o=1 the next cycle; stream with out_ready_i toggling every cycle yields 0,1,2,3,4,10,...,34; res_ready_o=0 throughout the 20 transfers.
- A_coeff_rot_i=0010 on the same cycle as an A load accept -> rotation dropped, A word order intact; err_o[1]=1 with POLY_BANK_ERR_EN.
- Assert reset_i=0 mid-drain after 7 transfers -> out_valid_o=0 immediately, RES=0, loaded_o=0, in_ready_o=1.
